core_mem_arbiter: RTL and testbench
===================================

CORE_MEM_ARBITER -- requirements
Module: core_mem_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4, meaning the number of data grants taken while an instruction request waits before the instruction port wins.
REQ-002 The block SHALL have port clk, input, 1 bit, the single core clock; all state updates on posedge clk.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have ports insn_req (in, 1), insn_addr (in, 30, word address), insn_ready (out, 1), insn_fault (out, 1) and insn_rdata (out, 32): the instruction-fetch requester.
REQ-005 The block SHALL have ports data_req (in, 1), data_addr (in, 30), data_write (in, 1), data_wdata (in, 32), data_be (in, 4) and data_lock (in, 1): the data requester.
REQ-006 The block SHALL have data return ports data_ready (out, 1), data_fault (out, 1) and data_rdata (out, 32).
REQ-007 The block SHALL have memory-side ports mem_start (out, 1), mem_addr (out, 30), mem_write (out, 1), mem_data_wr (out, 32), mem_be (out, 4), mem_ready (in, 1), mem_fault (in, 1) and mem_data_rd (in, 32).

Function
REQ-008 The block SHALL use requester protocol: *_req held high with stable address/data until the matching *_ready pulses high for exactly one cycle; *_fault and *_rdata are valid only in that cycle.
REQ-009 The block SHALL implement an FSM with states IDLE, INSN and DATA; exactly one owner per transaction.
REQ-010 In IDLE, the block SHALL: grant INSN if insn_req and (!data_req or starve == STARVE_LIMIT); else grant DATA if data_req; else stay IDLE.
REQ-011 On grant, the block SHALL latch the owner's address, write, wdata and be into registers, and the mem_* outputs SHALL be driven only from those registers.
REQ-012 The block SHALL assert mem_start for exactly one cycle: the first cycle in INSN or DATA. Latency from req sampled in IDLE to mem_start is 1 cycle.
REQ-013 For INSN transactions, mem_write and mem_be SHALL be 0 and 4'b1111 respectively.
REQ-014 While in INSN/DATA with mem_ready=0, the block SHALL hold state and all mem_* registers.
REQ-015 When mem_ready=1, the block SHALL pulse the owner's *_ready combinationally in the same cycle, pass mem_fault and mem_data_rd to the owner's *_fault and *_rdata, and hold the other port's ready/fault at 0.
REQ-016 On completion of DATA with data_lock=1 and data_req=1, the block SHALL go directly to a new DATA transaction (relatch, mem_start next cycle), ignoring starvation; otherwise it returns to IDLE.
REQ-017 The starve counter SHALL be 3 bits wide and saturate at STARVE_LIMIT; it increments on each DATA grant (including locked re-grants) taken while insn_req=1, and clears on each INSN grant.
REQ-018 The block SHALL treat a fault as a normal completion: no retry, and the FSM proceeds per REQ-015/016.
REQ-019 If a requester deasserts *_req mid-transaction (a protocol violation), the block SHALL still complete the memory transaction and pulse *_ready.
REQ-020 When mem_ready is high in IDLE, the block SHALL ignore it and produce no ready pulses.

Reset
REQ-021 While rst=1 at a clock edge, the block SHALL go to state IDLE, set starve=0, clear all latched mem_* registers, and drive mem_start, insn_ready, data_ready, insn_fault and data_fault to 0.
REQ-022 If rst is asserted mid-transaction, the block SHALL drop the transaction with no ready pulse to either requester and never reissue it; the first mem_start after reset SHALL come at least 1 cycle after rst falls.

Verification
REQ-023 Bench scenario, single fetch: insn_req=1, addr=0x100, mem_ready after 3 cycles with rdata=0xE3A00001 -> mem_start one cycle, mem_write=0, mem_be=1111, insn_ready pulse with insn_rdata=0xE3A00001, state back to IDLE.
REQ-024 Bench scenario, contention: insn_req and data_req both asserted in the same IDLE cycle, starve=0 -> DATA granted first, starve=1, INSN granted after data completes.
REQ-025 Bench scenario, starvation: data_req held continuously unlocked with insn_req high and STARVE_LIMIT=4 -> exactly 4 data transactions, then 1 insn transaction, then starve=0.
REQ-026 Bench scenario, locked burst: data_lock=1 for 3 writes, addrs 0x40, 0x41, 0x42, insn_req high throughout -> three back-to-back DATA transactions with no IDLE cycle between them, then insn is served.
REQ-027 Bench scenario, fault: a data read completes with mem_fault=1 -> data_ready=1 and data_fault=1 in the same cycle, insn_fault=0, no retry.
REQ-028 Bench scenario, reset mid-operation: rst=1 during a DATA transaction awaiting mem_ready -> no data_ready pulse, IDLE next cycle, and a new request after reset is served normally.

Source files
------------

// File: rtl/core_mem_arbiter.sv
// rtl/core_mem_arbiter.sv - two-requester (instruction/data) arbiter onto one memory port
//
// Ports:
//   clk, rst                 core clock; synchronous active-high reset
//   insn_req/insn_addr       instruction-fetch request (word address)
//   insn_ready/fault/rdata   instruction completion, valid only while insn_ready=1
//   data_req/addr/write/     data request; data_lock chains back-to-back
//     wdata/be/lock          transactions without returning to IDLE
//   data_ready/fault/rdata   data completion, valid only while data_ready=1
//   mem_start/addr/write/    memory command, all driven from latched registers;
//     data_wr/be             mem_start pulses on the first cycle of a transaction
//   mem_ready/fault/data_rd  memory completion strobe and response
//
// STARVE_LIMIT: data grants taken while an instruction fetch waits before the
// instruction port is forced to win (counter is 3 bits, so at most 7).
module core_mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        insn_req,
  input  logic [29:0] insn_addr,
  output logic        insn_ready,
  output logic        insn_fault,
  output logic [31:0] insn_rdata,

  input  logic        data_req,
  input  logic [29:0] data_addr,
  input  logic        data_write,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_be,
  input  logic        data_lock,
  output logic        data_ready,
  output logic        data_fault,
  output logic [31:0] data_rdata,

  output logic        mem_start,
  output logic [29:0] mem_addr,
  output logic        mem_write,
  output logic [31:0] mem_data_wr,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic        mem_fault,
  input  logic [31:0] mem_data_rd
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INSN = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  state_t     state;
  logic [2:0] starve;

  logic starved;
  logic grant_insn;
  logic grant_data;
  logic relock;
  logic load_data;
  logic starve_inc;

  assign starved    = (starve == LIMIT);
  assign grant_insn = (state == IDLE) && insn_req && (!data_req || starved);
  assign grant_data = (state == IDLE) && !grant_insn && data_req;
  // A locked data completion immediately re-grants data, bypassing starvation.
  assign relock     = (state == DATA) && mem_ready && data_lock && data_req;
  assign load_data  = grant_data || relock;
  // Only data grants taken while a fetch is actually waiting count as starvation.
  assign starve_inc = load_data && insn_req && (starve != LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      starve      <= 3'd0;
      mem_start   <= 1'b0;
      mem_addr    <= 30'd0;
      mem_write   <= 1'b0;
      mem_data_wr <= 32'd0;
      mem_be      <= 4'd0;
    end else begin
      mem_start <= 1'b0;

      if (grant_insn) begin
        mem_start   <= 1'b1;
        mem_addr    <= insn_addr;
        mem_write   <= 1'b0;
        mem_data_wr <= 32'd0;
        mem_be      <= 4'b1111;
        starve      <= 3'd0;
      end else if (load_data) begin
        mem_start   <= 1'b1;
        mem_addr    <= data_addr;
        mem_write   <= data_write;
        mem_data_wr <= data_wdata;
        mem_be      <= data_be;
        if (starve_inc) begin
          starve <= starve + 3'd1;
        end
      end

      case (state)
        IDLE: begin
          if (grant_insn) begin
            state <= INSN;
          end else if (grant_data) begin
            state <= DATA;
          end
        end
        INSN: begin
          if (mem_ready) begin
            state <= IDLE;
          end
        end
        DATA: begin
          if (mem_ready && !relock) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Completion is returned combinationally in the mem_ready cycle; reset
  // suppresses it so a dropped transaction never reports back.
  assign insn_ready = !rst && (state == INSN) && mem_ready;
  assign data_ready = !rst && (state == DATA) && mem_ready;
  assign insn_fault = insn_ready && mem_fault;
  assign data_fault = data_ready && mem_fault;
  assign insn_rdata = insn_ready ? mem_data_rd : 32'd0;
  assign data_rdata = data_ready ? mem_data_rd : 32'd0;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb/tb_core_mem_arbiter.sv - self-checking bench for core_mem_arbiter
module tb_core_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        insn_req;
  logic [29:0] insn_addr;
  logic        insn_ready;
  logic        insn_fault;
  logic [31:0] insn_rdata;
  logic        data_req;
  logic [29:0] data_addr;
  logic        data_write;
  logic [31:0] data_wdata;
  logic [3:0]  data_be;
  logic        data_lock;
  logic        data_ready;
  logic        data_fault;
  logic [31:0] data_rdata;
  logic        mem_start;
  logic [29:0] mem_addr;
  logic        mem_write;
  logic [31:0] mem_data_wr;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic        mem_fault;
  logic [31:0] mem_data_rd;

  int checks = 0;
  int errors = 0;

  core_mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .insn_req(insn_req), .insn_addr(insn_addr), .insn_ready(insn_ready),
    .insn_fault(insn_fault), .insn_rdata(insn_rdata),
    .data_req(data_req), .data_addr(data_addr), .data_write(data_write),
    .data_wdata(data_wdata), .data_be(data_be), .data_lock(data_lock),
    .data_ready(data_ready), .data_fault(data_fault), .data_rdata(data_rdata),
    .mem_start(mem_start), .mem_addr(mem_addr), .mem_write(mem_write),
    .mem_data_wr(mem_data_wr), .mem_be(mem_be), .mem_ready(mem_ready),
    .mem_fault(mem_fault), .mem_data_rd(mem_data_rd)
  );

  logic [1:0] st_act;
  logic [2:0] stv_act;
  assign st_act  = dut.state;
  assign stv_act = dut.starve;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_INSN = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst, ireq, dreq, dlock, mrdy, mflt;
    logic [1:0] st;
    logic [2:0] stv;
    logic       ms, ir, dr, ifl, dfl;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic ir_q, input logic dr_q,
                              input logic dl, input logic mr, input logic mf,
                              input logic [1:0] st, input logic [2:0] stv,
                              input logic ms, input logic ir, input logic dr,
                              input logic ifl, input logic dfl);
    vec_t v;
    v.rst = r; v.ireq = ir_q; v.dreq = dr_q; v.dlock = dl; v.mrdy = mr; v.mflt = mf;
    v.st = st; v.stv = stv; v.ms = ms; v.ir = ir; v.dr = dr; v.ifl = ifl; v.dfl = dfl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; insn_req = 1'b0; insn_addr = 30'd0;
    data_req = 1'b0; data_addr = 30'd0; data_write = 1'b0; data_wdata = 32'd0;
    data_be = 4'd0; data_lock = 1'b0; mem_ready = 1'b0; mem_fault = 1'b0;
    mem_data_rd = 32'd0;

    // Reset state, with requests and mem_ready active to show they are ignored.
    @(negedge clk);
    insn_req = 1'b1; data_req = 1'b1; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_state", st_act, S_IDLE);
    chk("rst_starve", stv_act, 3'd0);
    chk("rst_mem_start", mem_start, 1'b0);
    chk("rst_insn_ready", insn_ready, 1'b0);
    chk("rst_data_ready", data_ready, 1'b0);
    chk("rst_mem_addr", mem_addr, 30'd0);
    chk("rst_mem_be", mem_be, 4'd0);

    @(negedge clk);
    rst = 1'b0; insn_req = 1'b0; data_req = 1'b0; mem_ready = 1'b0;

    // Single fetch with three wait cycles.
    @(negedge clk);
    insn_req = 1'b1; insn_addr = 30'h100;
    #1 chk("sf_idle", st_act, S_IDLE);
    @(negedge clk); #1;
    chk("sf_start", mem_start, 1'b1);
    chk("sf_addr", mem_addr, 30'h100);
    chk("sf_write", mem_write, 1'b0);
    chk("sf_be", mem_be, 4'b1111);
    chk("sf_state", st_act, S_INSN);
    @(negedge clk); #1;
    chk("sf_start_once", mem_start, 1'b0);
    chk("sf_addr_hold", mem_addr, 30'h100);
    chk("sf_wait_ready", insn_ready, 1'b0);
    @(negedge clk);
    @(negedge clk);
    mem_ready = 1'b1; mem_data_rd = 32'hE3A00001;
    #1;
    chk("sf_ready", insn_ready, 1'b1);
    chk("sf_rdata", insn_rdata, 32'hE3A00001);
    chk("sf_fault", insn_fault, 1'b0);
    chk("sf_data_ready", data_ready, 1'b0);
    @(negedge clk);
    insn_req = 1'b0; mem_ready = 1'b0;
    #1;
    chk("sf_back_idle", st_act, S_IDLE);
    chk("sf_ready_drop", insn_ready, 1'b0);

    // Cycle-by-cycle table: contention, mem_ready in IDLE, starvation.
    insn_addr = 30'h200; data_addr = 30'h20; data_write = 1'b0; data_be = 4'hF;
    //             rst ireq dreq lock mrdy mflt  st      stv  ms ir dr if df
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, S_IDLE, 3'd0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, S_DATA, 3'd1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 1, 0, S_DATA, 3'd1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, S_IDLE, 3'd1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, S_INSN, 3'd0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, S_IDLE, 3'd0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, S_IDLE, 3'd0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 1, 0, S_DATA, 3'd1, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, S_IDLE, 3'd1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 1, 0, S_DATA, 3'd2, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, S_IDLE, 3'd2, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 1, 0, S_DATA, 3'd3, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, S_IDLE, 3'd3, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 1, 0, S_DATA, 3'd4, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, S_IDLE, 3'd4, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 1, 0, S_INSN, 3'd0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, S_IDLE, 3'd0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, S_DATA, 3'd0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 0, S_DATA, 3'd0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, S_IDLE, 3'd0, 0, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst = tbl[i].rst; insn_req = tbl[i].ireq; data_req = tbl[i].dreq;
      data_lock = tbl[i].dlock; mem_ready = tbl[i].mrdy; mem_fault = tbl[i].mflt;
      #1;
      chk($sformatf("v%0d_state", i), st_act, tbl[i].st);
      chk($sformatf("v%0d_starve", i), stv_act, tbl[i].stv);
      chk($sformatf("v%0d_mem_start", i), mem_start, tbl[i].ms);
      chk($sformatf("v%0d_insn_ready", i), insn_ready, tbl[i].ir);
      chk($sformatf("v%0d_data_ready", i), data_ready, tbl[i].dr);
      chk($sformatf("v%0d_insn_fault", i), insn_fault, tbl[i].ifl);
      chk($sformatf("v%0d_data_fault", i), data_fault, tbl[i].dfl);
    end

    // Locked burst of three writes with a fetch pending throughout.
    @(negedge clk);
    mem_ready = 1'b0; insn_req = 1'b1; insn_addr = 30'h300;
    data_req = 1'b1; data_lock = 1'b1; data_write = 1'b1;
    data_addr = 30'h40; data_wdata = 32'hA0000000; data_be = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      chk($sformatf("lb%0d_state", k), st_act, S_DATA);
      chk($sformatf("lb%0d_start", k), mem_start, 1'b1);
      chk($sformatf("lb%0d_addr", k), mem_addr, 30'h40 + 30'(k));
      chk($sformatf("lb%0d_wdata", k), mem_data_wr, 32'hA0000000 + 32'(k));
      chk($sformatf("lb%0d_be", k), mem_be, 4'b0001 << k);
      chk($sformatf("lb%0d_write", k), mem_write, 1'b1);
      chk($sformatf("lb%0d_ready", k), data_ready, 1'b1);
      chk($sformatf("lb%0d_starve", k), stv_act, 3'(k + 1));
      if (k < 2) begin
        data_addr = 30'h41 + 30'(k); data_wdata = 32'hA0000001 + 32'(k);
        data_be = 4'b0010 << k;
      end else begin
        data_req = 1'b0; data_lock = 1'b0;
      end
    end
    @(negedge clk);
    mem_ready = 1'b0;
    #1 chk("lb_idle", st_act, S_IDLE);
    @(negedge clk);
    mem_ready = 1'b1; mem_data_rd = 32'h0BADF00D;
    #1;
    chk("lb_insn_state", st_act, S_INSN);
    chk("lb_insn_addr", mem_addr, 30'h300);
    chk("lb_insn_write", mem_write, 1'b0);
    chk("lb_insn_ready", insn_ready, 1'b1);
    @(negedge clk);
    insn_req = 1'b0; mem_ready = 1'b0;
    #1 chk("lb_starve_clr", stv_act, 3'd0);

    // Data read completing with a fault: reported once, never retried.
    @(negedge clk);
    data_req = 1'b1; data_write = 1'b0; data_addr = 30'h55; data_be = 4'hF;
    @(negedge clk);
    #1 chk("ft_start", mem_start, 1'b1);
    @(negedge clk);
    mem_ready = 1'b1; mem_fault = 1'b1; mem_data_rd = 32'hDEADBEEF;
    #1;
    chk("ft_ready", data_ready, 1'b1);
    chk("ft_fault", data_fault, 1'b1);
    chk("ft_insn_fault", insn_fault, 1'b0);
    chk("ft_insn_ready", insn_ready, 1'b0);
    @(negedge clk);
    data_req = 1'b0; mem_ready = 1'b0; mem_fault = 1'b0;
    #1 chk("ft_idle", st_act, S_IDLE);
    @(negedge clk);
    #1 chk("ft_no_retry", mem_start, 1'b0);

    // Reset while a data transaction waits for memory.
    @(negedge clk);
    data_req = 1'b1; data_addr = 30'h77;
    @(negedge clk);
    #1 chk("rm_start", mem_start, 1'b1);
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b1;
    #1 chk("rm_no_ready", data_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0; data_req = 1'b0; mem_ready = 1'b0;
    #1;
    chk("rm_idle", st_act, S_IDLE);
    chk("rm_addr_clr", mem_addr, 30'd0);
    chk("rm_start_low", mem_start, 1'b0);
    @(negedge clk);
    data_req = 1'b1; data_addr = 30'h78;
    #1 chk("rm_no_reissue", mem_start, 1'b0);
    @(negedge clk);
    mem_ready = 1'b1; mem_data_rd = 32'h12345678;
    #1;
    chk("rm_new_start", mem_start, 1'b1);
    chk("rm_new_addr", mem_addr, 30'h78);
    chk("rm_new_ready", data_ready, 1'b1);
    chk("rm_new_rdata", data_rdata, 32'h12345678);
    @(negedge clk);
    data_req = 1'b0; mem_ready = 1'b0;
    #1 chk("rm_end_idle", st_act, S_IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
